instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have one clock, clk_i; reset rst_i SHALL be synchronous and active-high.
REQ-002 Ports SHALL be, clock and reset first:
  clk_i  in  1  clock
  rst_i  in  1  sync active-high reset
  start_i  in  1  core run enable
  pc_i  in  32  current PC from PC register
  pc_stall_o  out  1  hold PC (drives PC flushPC_i)
  imem_req_o  out  1  instruction memory request
  imem_addr_o  out  32  fetch address
  imem_ack_i  in  1  memory data valid, only meaningful while imem_req_o=1
  imem_data_i  in  32  fetched instruction
  stall_i  in  1  hazard stall from decode
  flush_i  in  1  taken branch/jump, squash fetch
  ifid_pc_o  out  32  IF/ID PC+4
  ifid_instr_o  out  32  IF/ID instruction
  ifid_valid_o  out  1  IF/ID holds a real instruction
REQ-003 Parameter: NOP_INSTR, default 32'h0000_0000, value loaded into ifid_instr_o on clear.

Function
REQ-004 FSM states SHALL be IDLE, FETCH, HOLD.
REQ-005 IDLE: imem_req_o=0, pc_stall_o=1; start_i=1 -> FETCH next edge.
REQ-006 FETCH: imem_req_o=1, imem_addr_o=pc_i; pc_stall_o=1 until an accepted ack.
REQ-007 FETCH, imem_ack_i=1, stall_i=0: IF/ID loads {pc_i+4, imem_data_i}, ifid_valid_o=1 next edge; pc_stall_o=0 that cycle; stay FETCH.
REQ-008 Same-cycle ack SHALL be supported: sustained throughput one instruction per clock.
REQ-009 FETCH, imem_ack_i=1, stall_i=1: IF/ID unchanged; {pc_i+4, imem_data_i} captured into hold buffer; pc_stall_o=0 that cycle; -> HOLD.
REQ-010 HOLD: imem_req_o=0, pc_stall_o=1; stall_i=0 -> IF/ID loads hold buffer, valid=1, -> FETCH.
REQ-011 FETCH, imem_ack_i=0, stall_i=1: request held, IF/ID unchanged.
REQ-012 PC+4 SHALL be 32-bit modulo: pc_i=32'hFFFF_FFFC gives ifid_pc_o=32'h0000_0000.
REQ-013 flush_i=1 (any state except IDLE): imem_req_o=0, ack ignored, pc_stall_o=0, IF/ID cleared (pc=0, instr=NOP_INSTR, valid=0), hold buffer dropped, -> FETCH next edge.
REQ-014 flush_i SHALL override stall_i and imem_ack_i in the same cycle.
REQ-015 start_i=0 in FETCH or HOLD: imem_req_o=0, pc_stall_o=1, -> IDLE; IF/ID retained; hold buffer discarded.
REQ-016 Outputs imem_req_o, imem_addr_o, pc_stall_o SHALL be combinational from state and inputs; IF/ID outputs registered.

Reset
REQ-017 rst_i=1 at an edge: state=IDLE, ifid_pc_o=0, ifid_instr_o=NOP_INSTR, ifid_valid_o=0, hold buffer cleared.
REQ-018 During reset cycle imem_req_o=0, pc_stall_o=1; reset SHALL override flush_i, stall_i, start_i, ack.
REQ-019 Reset mid-fetch SHALL abandon the outstanding request; a later ack SHALL be ignored unless imem_req_o=1.

Structure
REQ-020 Shared package SHALL hold the FSM state encoding, NOP_INSTR default and PC_INCR=4.
REQ-021 One sub-module, ifid_reg (32+32+1 register with load enable and synchronous clear), SHALL implement the IF/ID latch.

Verification
REQ-022 Reset then start_i=1, pc_i=0x0, 0x4, 0x8, ack every cycle, data 0xA,0xB,0xC -> ifid = (0x4,0xA),(0x8,0xB),(0xC,0xC), valid=1 consecutive cycles, pc_stall_o=0.
REQ-023 pc_i=0x100, ack delayed 3 cycles, data 0x2402_0005 -> pc_stall_o=1 for 3 cycles, then ifid=(0x104,0x2402_0005).
REQ-024 ack with stall_i=1 for 2 cycles at pc_i=0x20, data 0x1234 -> HOLD, ifid unchanged for 2 cycles, then ifid=(0x24,0x1234), then FETCH.
REQ-025 flush_i=1 with stall_i=1 and ack=1 same cycle -> imem_req_o=0, pc_stall_o=0, next ifid_valid_o=0, ifid_instr_o=NOP_INSTR.
REQ-026 pc_i=0xFFFF_FFFC acked -> ifid_pc_o=0x0.
REQ-027 rst_i=1 while waiting for ack, ack arrives next cycle -> req=0, state IDLE, ifid unchanged at reset values.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds FSM encoding, IF/ID bundle layout and fetch constants.
package instr_fetch_unit_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
   } if_id_t;

   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
   localparam logic [31:0] PC_INCR       = 32'd4;

   function automatic if_id_t ifid_bubble(input logic [31:0] nop);
      if_id_t b;
      b.pc    = '0;
      b.instr = nop;
      b.valid = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_ifid_reg.sv
// IF/ID pipeline latch: 32+32+1 bits, load enable, synchronous clear.
// Clear wins over load so a flush can never be overwritten by a fetch.
module ifid_reg
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   clr,
   input  logic   load,
   input  if_id_t d,
   output if_id_t q
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= ifid_bubble(NOP_INSTR);
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: drives imem, feeds IF/ID, handles
// decode stalls through a one-entry hold buffer and branch flushes.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] pc_i,
   output logic        pc_stall_o,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic [31:0] ifid_pc_o,
   output logic [31:0] ifid_instr_o,
   output logic        ifid_valid_o
);

   state_t      state;
   if_id_t      hold;
   if_id_t      ifid_d;
   if_id_t      ifid_q;
   logic        ifid_load;
   logic        ifid_clr;
   logic [31:0] pc_next;

   assign pc_next = pc_i + PC_INCR;

   // Handshake outputs stay combinational so a same-cycle ack
   // releases the PC immediately and sustains one fetch per clock.
   always_comb begin
      imem_req_o   = 1'b0;
      imem_addr_o  = pc_i;
      pc_stall_o   = 1'b1;
      ifid_load    = 1'b0;
      ifid_clr     = 1'b0;
      ifid_d.pc    = pc_next;
      ifid_d.instr = imem_data_i;
      ifid_d.valid = 1'b1;
      if (!rst_i) begin
         unique case (state)
            S_IDLE: begin
               pc_stall_o = 1'b1;
            end
            S_FETCH: begin
               if (!start_i) begin
                  pc_stall_o = 1'b1;
               end else if (flush_i) begin
                  pc_stall_o = 1'b0;
                  ifid_clr   = 1'b1;
               end else begin
                  imem_req_o = 1'b1;
                  pc_stall_o = !imem_ack_i;
                  ifid_load  = imem_ack_i && !stall_i;
               end
            end
            S_HOLD: begin
               if (!start_i) begin
                  pc_stall_o = 1'b1;
               end else if (flush_i) begin
                  pc_stall_o = 1'b0;
                  ifid_clr   = 1'b1;
               end else begin
                  ifid_load = !stall_i;
                  ifid_d    = hold;
               end
            end
            default: begin
               pc_stall_o = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= S_IDLE;
         hold  <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start_i) state <= S_FETCH;
            end
            S_FETCH: begin
               if (!start_i) begin
                  state <= S_IDLE;
                  hold  <= '0;
               end else if (flush_i) begin
                  state <= S_FETCH;
                  hold  <= '0;
               end else if (imem_ack_i && stall_i) begin
                  state <= S_HOLD;
                  hold  <= ifid_d;
               end
            end
            S_HOLD: begin
               if (!start_i) begin
                  state <= S_IDLE;
                  hold  <= '0;
               end else if (flush_i || !stall_i) begin
                  state <= S_FETCH;
                  hold  <= '0;
               end
            end
            default: begin
               state <= S_IDLE;
               hold  <= '0;
            end
         endcase
      end
   end

   ifid_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid (
      .clk  (clk_i),
      .rst  (rst_i),
      .clr  (ifid_clr),
      .load (ifid_load),
      .d    (ifid_d),
      .q    (ifid_q)
   );

   assign ifid_pc_o    = ifid_q.pc;
   assign ifid_instr_o = ifid_q.instr;
   assign ifid_valid_o = ifid_q.valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit.
// Expected values are hand-computed per step.
module tb_instr_fetch_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [31:0] pc_i;
   logic        pc_stall_o;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_data_i;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] ifid_pc_o;
   logic [31:0] ifid_instr_o;
   logic        ifid_valid_o;

   int n_assert = 0;
   int n_fail   = 0;

   instr_fetch_unit dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .pc_i         (pc_i),
      .pc_stall_o   (pc_stall_o),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_ack_i   (imem_ack_i),
      .imem_data_i  (imem_data_i),
      .stall_i      (stall_i),
      .flush_i      (flush_i),
      .ifid_pc_o    (ifid_pc_o),
      .ifid_instr_o (ifid_instr_o),
      .ifid_valid_o (ifid_valid_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] p,
                           input logic [31:0] ins, input logic v);
      chk({tag, "_pc"}, ifid_pc_o, p);
      chk({tag, "_instr"}, ifid_instr_o, ins);
      chk({tag, "_valid"}, {31'b0, ifid_valid_o}, {31'b0, v});
   endtask

   task automatic chk_hs(input string tag, input logic req,
                         input logic pstall);
      chk({tag, "_req"}, {31'b0, imem_req_o}, {31'b0, req});
      chk({tag, "_pcstall"}, {31'b0, pc_stall_o}, {31'b0, pstall});
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; pc_i = '0;
      imem_ack_i = 1'b0; imem_data_i = '0;
      stall_i = 1'b0; flush_i = 1'b0;
      tick();
      tick();
      chk_hs("rst", 1'b0, 1'b1);
      chk_ifid("rst", 32'h0, 32'h0, 1'b0);

      rst_i = 1'b0;
      #1 chk_hs("idle", 1'b0, 1'b1);
      start_i = 1'b1;
      tick();

      // back-to-back fetches, ack every cycle
      pc_i = 32'h0; imem_ack_i = 1'b1; imem_data_i = 32'hA;
      #1 chk_hs("f0", 1'b1, 1'b0);
      chk("f0_addr", imem_addr_o, 32'h0);
      tick();
      chk_ifid("f0", 32'h4, 32'hA, 1'b1);
      pc_i = 32'h4; imem_data_i = 32'hB;
      #1 chk_hs("f1", 1'b1, 1'b0);
      tick();
      chk_ifid("f1", 32'h8, 32'hB, 1'b1);
      pc_i = 32'h8; imem_data_i = 32'hC;
      #1 chk_hs("f2", 1'b1, 1'b0);
      tick();
      chk_ifid("f2", 32'hC, 32'hC, 1'b1);

      // ack delayed three cycles
      pc_i = 32'h100; imem_ack_i = 1'b0; imem_data_i = 32'h0;
      for (int i = 0; i < 3; i++) begin
         #1 chk_hs("wait", 1'b1, 1'b1);
         chk("wait_addr", imem_addr_o, 32'h100);
         tick();
         chk_ifid("wait", 32'hC, 32'hC, 1'b1);
      end
      imem_ack_i = 1'b1; imem_data_i = 32'h2402_0005;
      #1 chk_hs("dack", 1'b1, 1'b0);
      tick();
      chk_ifid("dack", 32'h104, 32'h2402_0005, 1'b1);

      // ack while decode stalls -> hold buffer
      pc_i = 32'h20; imem_data_i = 32'h1234; stall_i = 1'b1;
      #1 chk_hs("hack", 1'b1, 1'b0);
      tick();
      chk_ifid("hack", 32'h104, 32'h2402_0005, 1'b1);
      imem_ack_i = 1'b0; imem_data_i = 32'hDEAD;
      #1 chk_hs("hold", 1'b0, 1'b1);
      tick();
      chk_ifid("hold", 32'h104, 32'h2402_0005, 1'b1);
      stall_i = 1'b0;
      #1 chk_hs("hrel", 1'b0, 1'b1);
      tick();
      chk_ifid("hrel", 32'h24, 32'h1234, 1'b1);
      #1 chk_hs("refetch", 1'b1, 1'b1);

      // PC wrap
      pc_i = 32'hFFFF_FFFC; imem_ack_i = 1'b1; imem_data_i = 32'h13;
      tick();
      chk_ifid("wrap", 32'h0, 32'h13, 1'b1);

      // flush beats stall and ack
      pc_i = 32'h200; stall_i = 1'b1; flush_i = 1'b1;
      imem_data_i = 32'h77;
      #1 chk_hs("flush", 1'b0, 1'b0);
      tick();
      chk_ifid("flush", 32'h0, 32'h0, 1'b0);
      flush_i = 1'b0; stall_i = 1'b0; imem_ack_i = 1'b0;
      #1 chk_hs("postflush", 1'b1, 1'b1);

      // run-enable drop keeps IF/ID
      pc_i = 32'h40; imem_ack_i = 1'b1; imem_data_i = 32'h55;
      tick();
      chk_ifid("ld40", 32'h44, 32'h55, 1'b1);
      start_i = 1'b0; imem_ack_i = 1'b0;
      #1 chk_hs("stop", 1'b0, 1'b1);
      tick();
      chk_ifid("stop", 32'h44, 32'h55, 1'b1);
      imem_ack_i = 1'b1; imem_data_i = 32'h66;
      #1 chk_hs("idle2", 1'b0, 1'b1);
      tick();
      chk_ifid("idle2", 32'h44, 32'h55, 1'b1);
      imem_ack_i = 1'b0;
      start_i = 1'b1;
      tick();

      // reset while waiting, late ack ignored
      pc_i = 32'h80;
      #1 chk_hs("w80", 1'b1, 1'b1);
      tick();
      rst_i = 1'b1; flush_i = 1'b1; stall_i = 1'b1;
      #1 chk_hs("rstmid", 1'b0, 1'b1);
      tick();
      chk_ifid("rstmid", 32'h0, 32'h0, 1'b0);
      rst_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0; start_i = 1'b0;
      imem_ack_i = 1'b1; imem_data_i = 32'h99;
      #1 chk_hs("lateack", 1'b0, 1'b1);
      tick();
      chk_ifid("lateack", 32'h0, 32'h0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
